// File: rtl/sca_trigger_gen.sv
// -----------------------------------------------------------------------------
// sca_trigger_gen
//
// Capture-trigger generator for side-channel measurement targets. A software
// trigger request is qualified with the busy status (~idle) of one selected
// crypto block. The block then drives a registered trigger pad.
//
// Modes (mode_i):
//   0 gated  : trig_o follows (sw & busy) with one cycle of latency.
//   1 window : single shot. Arm on a rising sw edge. Then trigger for as long
//              as the latched block stays busy.
//   2 pulse  : single shot. Arm on a rising sw edge. Busy then starts a
//              delay_i cycle wait, followed by a trigger pulse width_i cycles
//              wide (a width of 0 counts as 1).
//   3 off    : trigger held low and the FSM held in Idle.
//
// Ports:
//   clk_i       block clock
//   rst_i       synchronous active-high reset
//   sw_trig_i   per-channel software trigger request (level)
//   idle_i      per-channel idle status (busy = ~idle)
//   sel_i       channel select; values >= NumChannels select nothing
//   mode_i      operating mode, see above
//   delay_i     pulse mode: cycles from busy detection to trigger
//   width_i     pulse mode: trigger width in cycles
//   trig_o      registered capture trigger
//   armed_o     registered, high while the FSM is Armed/Delay/Active
//   trig_cnt_o  saturating count of trig_o rising edges
//
// Interface semantics: there is no valid/ready handshake. Every input is a
// level sampled on each rising clk_i edge. Every output is a register that
// changes only on that edge, so no combinational path runs from an input to
// an output.
//
// The FSM state is held in state_q (type state_e) and can be probed by name.
// -----------------------------------------------------------------------------
module sca_trigger_gen #(
  parameter int NumChannels = 4,
  parameter int CntW        = 16,
  parameter int SelW        = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumChannels-1:0] sw_trig_i,
  input  logic [NumChannels-1:0] idle_i,
  input  logic [SelW-1:0]        sel_i,
  input  logic [1:0]             mode_i,
  input  logic [CntW-1:0]        delay_i,
  input  logic [CntW-1:0]        width_i,
  output logic                   trig_o,
  output logic                   armed_o,
  output logic [CntW-1:0]        trig_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_DELAY  = 2'd2,
    ST_ACTIVE = 2'd3
  } state_e;

  localparam logic [1:0] MODE_GATED  = 2'd0;
  localparam logic [1:0] MODE_WINDOW = 2'd1;
  localparam logic [1:0] MODE_PULSE  = 2'd2;
  localparam logic [1:0] MODE_OFF    = 2'd3;

  localparam logic [CntW-1:0] CNT_ONE = CntW'(1);
  localparam logic [CntW-1:0] CNT_MAX = {CntW{1'b1}};

  state_e          state_q, state_d;
  logic [SelW-1:0] sel_q, sel_d, sel_eff;
  logic [1:0]      mode_q, mode_d;
  logic [CntW-1:0] delay_q, delay_d;
  logic [CntW-1:0] width_q, width_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] trig_cnt_q, trig_cnt_d;
  logic            sw_q;
  logic            trig_q, trig_d;
  logic            armed_q, armed_d;
  logic            sw, busy, sw_rise;
  logic            live_abort;

  // In Idle the live selection is used. Once the FSM is armed, the selection
  // latched at arm time is used so that sel_i changes cannot redirect the
  // trigger.
  assign sel_eff = (state_q == ST_IDLE) ? sel_i : sel_q;

  // Channel mux. An out-of-range select leaves both sw and busy low.
  always_comb begin
    sw   = 1'b0;
    busy = 1'b0;
    for (int i = 0; i < NumChannels; i++) begin
      if (sel_eff == SelW'(i)) begin
        sw   = sw_trig_i[i];
        busy = ~idle_i[i];
      end
    end
  end

  // sw_q resets to 1. A request that is already high when reset is released
  // therefore needs a low phase before it can arm.
  assign sw_rise = sw & ~sw_q;

  // A live mode of gated or off kills any single-shot sequence in progress.
  assign live_abort = (state_q != ST_IDLE) &&
                      ((mode_i == MODE_GATED) || (mode_i == MODE_OFF));

  // Next-state, latch and counter logic.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    mode_d  = mode_q;
    delay_d = delay_q;
    width_d = width_q;
    cnt_d   = cnt_q;
    trig_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (mode_i == MODE_GATED) begin
          trig_d = sw & busy;
        end else if ((mode_i != MODE_OFF) && sw_rise) begin
          state_d = ST_ARMED;
          sel_d   = sel_i;
          mode_d  = mode_i;
          delay_d = delay_i;
          width_d = (width_i == '0) ? CNT_ONE : width_i;
        end
      end

      ST_ARMED: begin
        // Busy is checked first, so a busy edge that coincides with the sw
        // request dropping still fires.
        if (busy) begin
          if (mode_q == MODE_WINDOW) begin
            state_d = ST_ACTIVE;
          end else if (delay_q == '0) begin
            state_d = ST_ACTIVE;
            cnt_d   = width_q;
          end else begin
            state_d = ST_DELAY;
            cnt_d   = delay_q;
          end
        end else if (!sw) begin
          state_d = ST_IDLE;
        end
      end

      ST_DELAY: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ST_ACTIVE;
          cnt_d   = width_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_ACTIVE: begin
        if (mode_q == MODE_WINDOW) begin
          if (!busy) begin
            state_d = ST_IDLE;
          end
        end else if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (live_abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end

    // In the single-shot modes the trigger is exactly "next state is Active".
    // This registers trig_o in the same cycle that the state enters Active.
    if (state_d == ST_ACTIVE) begin
      trig_d = 1'b1;
    end
  end

  assign armed_d = (state_d != ST_IDLE);

  always_comb begin
    trig_cnt_d = trig_cnt_q;
    if (trig_d && !trig_q && (trig_cnt_q != CNT_MAX)) begin
      trig_cnt_d = trig_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      mode_q     <= MODE_GATED;
      delay_q    <= '0;
      width_q    <= '0;
      cnt_q      <= '0;
      trig_cnt_q <= '0;
      sw_q       <= 1'b1;
      trig_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      mode_q     <= mode_d;
      delay_q    <= delay_d;
      width_q    <= width_d;
      cnt_q      <= cnt_d;
      trig_cnt_q <= trig_cnt_d;
      sw_q       <= sw;
      trig_q     <= trig_d;
      armed_q    <= armed_d;
    end
  end

  assign trig_o     = trig_q;
  assign armed_o    = armed_q;
  assign trig_cnt_o = trig_cnt_q;

endmodule

// File: tb/tb_sca_trigger_gen.sv
// -----------------------------------------------------------------------------
// Bench for sca_trigger_gen. Two instances share one stimulus stream:
//   dut_a : CntW = 16, which carries the functional scenarios
//   dut_b : CntW = 2, whose delay and width inputs are truncated to 2 bits;
//           it exercises saturation of the trigger counter
// Both instances use NumChannels = 3, so sel = 3 is an out-of-range select.
//
// The reference model is a session-based description:
//   session 0 : no session open
//   session 1 : waiting for busy
//   session 2 : busy window open
//   session 3 : pulse scheduled on absolute cycle numbers [start, stop]
// -----------------------------------------------------------------------------
module tb_sca_trigger_gen;

  localparam int N    = 3;
  localparam int SELW = 2;
  localparam int EW   = 22;

  logic            clk;
  logic            rst;
  logic [N-1:0]    sw_trig;
  logic [N-1:0]    idle;
  logic [SELW-1:0] sel;
  logic [1:0]      mode;
  logic [15:0]     delay;
  logic [15:0]     width;

  logic            trig_a, armed_a;
  logic [15:0]     cnt_a;
  logic            trig_b, armed_b;
  logic [1:0]      cnt_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hi_cnt = 0;

  logic [EW-1:0] exp_q[$];

  // ---------------------------------------------------------------- clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------- DUTs
  sca_trigger_gen #(.NumChannels(N), .CntW(16)) dut_a (
    .clk_i      (clk),
    .rst_i      (rst),
    .sw_trig_i  (sw_trig),
    .idle_i     (idle),
    .sel_i      (sel),
    .mode_i     (mode),
    .delay_i    (delay),
    .width_i    (width),
    .trig_o     (trig_a),
    .armed_o    (armed_a),
    .trig_cnt_o (cnt_a)
  );

  sca_trigger_gen #(.NumChannels(N), .CntW(2)) dut_b (
    .clk_i      (clk),
    .rst_i      (rst),
    .sw_trig_i  (sw_trig),
    .idle_i     (idle),
    .sel_i      (sel),
    .mode_i     (mode),
    .delay_i    (delay[1:0]),
    .width_i    (width[1:0]),
    .trig_o     (trig_b),
    .armed_o    (armed_b),
    .trig_cnt_o (cnt_b)
  );

  // ---------------------------------------------------------------- model
  typedef struct {
    int          sess;
    bit          sw_q;
    bit          trig;
    int unsigned tcnt;
    int          lsel;
    int          lmode;
    int          ld;
    int          lw;
    int          start;
    int          stop;
  } mdl_t;

  mdl_t m_a;
  mdl_t m_b;

  // Advances one model across the clock edge numbered cyc. The returned
  // struct holds the state and outputs seen just after that edge.
  function automatic mdl_t mdl_step(input mdl_t m, input int unsigned cmax,
                                    input int c, input bit r,
                                    input logic [N-1:0] swv,
                                    input logic [N-1:0] idv,
                                    input int s_live, input int md,
                                    input int dly, input int wid);
    mdl_t o;
    int   s;
    bit   sw, busy, rise, nt;
    o = m;
    if (r) begin
      o.sess = 0;
      o.sw_q = 1'b1;
      o.trig = 1'b0;
      o.tcnt = 0;
      return o;
    end
    s    = (m.sess == 0) ? s_live : m.lsel;
    sw   = (s < N) ? swv[s] : 1'b0;
    busy = (s < N) ? !idv[s] : 1'b0;
    rise = sw && !m.sw_q;
    o.sw_q = sw;
    nt = 1'b0;
    if (m.sess != 0 && (md == 0 || md == 3)) begin
      o.sess = 0;
    end else begin
      case (m.sess)
        0: begin
          if (md == 0) begin
            nt = sw && busy;
          end else if (md != 3 && rise) begin
            o.sess  = 1;
            o.lsel  = s_live;
            o.lmode = md;
            o.ld    = dly;
            o.lw    = (wid == 0) ? 1 : wid;
          end
        end
        1: begin
          if (busy) begin
            if (m.lmode == 1) begin
              o.sess = 2;
            end else begin
              o.sess  = 3;
              o.start = c + m.ld;
              o.stop  = c + m.ld + m.lw - 1;
            end
          end else if (!sw) begin
            o.sess = 0;
          end
        end
        2: if (!busy) o.sess = 0;
        default: if (c > m.stop) o.sess = 0;
      endcase
      if (o.sess == 2) nt = 1'b1;
      if (o.sess == 3 && c >= o.start && c <= o.stop) nt = 1'b1;
    end
    if (nt && !m.trig && o.tcnt < cmax) o.tcnt = o.tcnt + 1;
    o.trig = nt;
    return o;
  endfunction

  // ---------------------------------------------------------------- checks
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: each cycle has one queued expectation.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("a_trig",  {31'd0, trig_a},  {31'd0, e[21]});
      check("a_armed", {31'd0, armed_a}, {31'd0, e[20]});
      check("a_cnt",   {16'd0, cnt_a},   {16'd0, e[19:4]});
      check("b_trig",  {31'd0, trig_b},  {31'd0, e[3]});
      check("b_armed", {31'd0, armed_b}, {31'd0, e[2]});
      check("b_cnt",   {30'd0, cnt_b},   {30'd0, e[1:0]});
      if (trig_a === 1'b1) hi_cnt++;
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic tick();
    m_a = mdl_step(m_a, 65535, cyc, rst, sw_trig, idle, int'(sel), int'(mode),
                   int'(delay), int'(width));
    m_b = mdl_step(m_b, 3, cyc, rst, sw_trig, idle, int'(sel), int'(mode),
                   int'(delay[1:0]), int'(width[1:0]));
    exp_q.push_back({m_a.trig, (m_a.sess != 0), 16'(m_a.tcnt),
                     m_b.trig, (m_b.sess != 0), 2'(m_b.tcnt)});
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reset, then leave one cycle with all requests low so that sw_q is 0.
  task automatic do_reset();
    rst     = 1'b1;
    sw_trig = '0;
    idle    = '1;
    sel     = '0;
    mode    = 2'd0;
    delay   = '0;
    width   = '0;
    ticks(2);
    rst = 1'b0;
    tick();
    hi_cnt = 0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    m_a = '{default: 0};
    m_b = '{default: 0};
    rst = 1'b1;
    sw_trig = '0;
    idle = '1;
    sel = '0;
    mode = 2'd0;
    delay = '0;
    width = '0;
    ticks(3);
    check("reset_trig",  {31'd0, trig_a},  0);
    check("reset_armed", {31'd0, armed_a}, 0);
    check("reset_cnt",   {16'd0, cnt_a},   0);
    rst = 1'b0;
    hi_cnt = 0;

    // Gated mode: 5 busy cycles produce a 5-cycle trigger and one count.
    mode = 2'd0;
    sel = 2'd0;
    sw_trig[0] = 1'b1;
    ticks(2);
    idle[0] = 1'b0;
    ticks(5);
    idle[0] = 1'b1;
    ticks(3);
    check("gated_hi",  hi_cnt, 5);
    check("gated_cnt", {16'd0, cnt_a}, 1);

    // Pulse mode, delay 3, width 4. The second burst has no re-arm.
    do_reset();
    mode = 2'd2;
    delay = 16'd3;
    width = 16'd4;
    sw_trig[0] = 1'b1;
    ticks(4);
    idle[0] = 1'b0;
    ticks(2);
    idle[0] = 1'b1;
    ticks(10);
    idle[0] = 1'b0;
    ticks(2);
    idle[0] = 1'b1;
    ticks(8);
    check("pulse_hi",    hi_cnt, 4);
    check("pulse_cnt",   {16'd0, cnt_a}, 1);
    check("pulse_armed", {31'd0, armed_a}, 0);

    // Pulse mode, delay 0, width 0: a single-cycle pulse.
    do_reset();
    mode = 2'd2;
    sw_trig[0] = 1'b1;
    ticks(3);
    idle[0] = 1'b0;
    tick();
    idle[0] = 1'b1;
    ticks(4);
    check("pulse0_hi", hi_cnt, 1);

    // Window mode. Arm on sel 2; later sel changes must be ignored.
    do_reset();
    mode = 2'd1;
    sel = 2'd2;
    sw_trig[2] = 1'b1;
    tick();
    sel = 2'd1;
    sw_trig[1] = 1'b1;
    idle[1] = 1'b0;
    ticks(2);
    idle[1] = 1'b1;
    ticks(2);
    check("latched_sel_hi",    hi_cnt, 0);
    check("latched_sel_armed", {31'd0, armed_a}, 1);
    idle[2] = 1'b0;
    ticks(7);
    idle[2] = 1'b1;
    ticks(3);
    check("window_hi", hi_cnt, 7);

    // Disarm before busy, then busy and sw drop in the same cycle.
    do_reset();
    mode = 2'd1;
    sw_trig[0] = 1'b1;
    ticks(2);
    check("arm_armed", {31'd0, armed_a}, 1);
    sw_trig[0] = 1'b0;
    ticks(2);
    check("disarm_armed", {31'd0, armed_a}, 0);
    idle[0] = 1'b0;
    ticks(2);
    idle[0] = 1'b1;
    tick();
    check("disarm_hi", hi_cnt, 0);
    sw_trig[0] = 1'b1;
    tick();
    sw_trig[0] = 1'b0;
    idle[0] = 1'b0;
    ticks(2);
    idle[0] = 1'b1;
    ticks(3);
    check("busy_wins_hi", hi_cnt, 2);

    // Reset in the middle of an Active pulse.
    do_reset();
    mode = 2'd2;
    width = 16'd10;
    sw_trig[0] = 1'b1;
    tick();
    idle[0] = 1'b0;
    ticks(3);
    rst = 1'b1;
    tick();
    check("midrst_trig", {31'd0, trig_a}, 0);
    check("midrst_cnt",  {16'd0, cnt_a},  0);
    rst = 1'b0;
    idle[0] = 1'b1;
    ticks(12);
    check("midrst_hi", hi_cnt, 3);

    // Counter saturation on the 2-bit instance, then off mode and out-of-range select.
    do_reset();
    mode = 2'd0;
    sw_trig[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle[0] = 1'b0;
      tick();
      idle[0] = 1'b1;
      tick();
    end
    tick();
    check("sat_cnt_a", {16'd0, cnt_a}, 5);
    check("sat_cnt_b", {30'd0, cnt_b}, 3);
    mode = 2'd3;
    idle[0] = 1'b0;
    ticks(3);
    mode = 2'd0;
    sel = 2'd3;
    sw_trig = '1;
    idle = '0;
    ticks(3);
    idle = '1;
    tick();
    check("off_oor_hi", hi_cnt, 5);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 5) == 0) sw_trig = N'($urandom);
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 3) == 0) idle[c] = ~idle[c];
      end
      if ($urandom_range(0, 19) == 0) begin
        mode = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3))
                                           : 2'($urandom_range(1, 2));
      end
      if ($urandom_range(0, 9) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        delay = 16'($urandom_range(0, 6));
        width = 16'($urandom_range(0, 6));
      end
      tick();
    end
    rst = 1'b0;
    ticks(2);
    @(negedge clk);
    #1;
    check("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
